// File: rtl/qe_input_filter_if.sv
// Pin-side bundle for the quadrature input conditioner.
//   en, a_raw, b_raw, err_ack : driven by the master (pins / control)
//   i_out, q_out              : filtered A/B levels toward the counter
//   up, dn, err               : single-clock step / illegal-transition pulses
//   err_sticky                : latched err, cleared by err_ack
interface qe_input_filter_if;
  logic en;
  logic a_raw;
  logic b_raw;
  logic err_ack;
  logic i_out;
  logic q_out;
  logic up;
  logic dn;
  logic err;
  logic err_sticky;

  modport master (
    output en, a_raw, b_raw, err_ack,
    input  i_out, q_out, up, dn, err, err_sticky
  );

  modport slave (
    input  en, a_raw, b_raw, err_ack,
    output i_out, q_out, up, dn, err, err_sticky
  );
endinterface

// File: rtl/qe_input_filter.sv
// Quadrature encoder pin conditioner.
// Synchronises raw A/B pins, rejects glitches with a per-channel stability
// filter advanced by a prescaled sample strobe, and decodes up/dn step pulses
// plus an err pulse for simultaneous changes on both filtered channels.
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset of every register
//   bus  : qe_input_filter_if.slave (en, a_raw, b_raw, err_ack in;
//          i_out, q_out, up, dn, err, err_sticky out)
module qe_input_filter #(
  parameter int unsigned DIV      = 1,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic               clk,
  input  logic               clr,
  qe_input_filter_if.slave   bus
);

  typedef enum logic {S_SETTLE, S_RUN} state_t;

  localparam logic [7:0] PRE_MAX  = 8'(DIV - 1);
  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [4:0] SETTLE_N = 5'(FILT_LEN + 2);

  // Bit 1 carries channel A (i), bit 0 carries channel B (q).
  logic [1:0] sync1, sync2, filt, prev;
  logic [3:0] fcnt [2];
  logic [7:0] pre_cnt;
  logic       strobe;
  logic [4:0] settle_cnt;
  state_t     state, state_nx;
  logic       up_q, dn_q, err_q, sticky_q;
  logic       up_nx, dn_nx, err_nx;

  // Synchroniser runs regardless of en.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.a_raw, bus.b_raw};
      sync2 <= sync1;
    end
  end

  assign strobe = bus.en && (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_cnt <= '0;
    end else if (bus.en) begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filt <= '0;
      for (int unsigned c = 0; c < 2; c++) fcnt[c] <= '0;
    end else if (strobe) begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (sync2[c] == filt[c]) begin
          fcnt[c] <= '0;
        end else if (fcnt[c] == FILT_MAX) begin
          filt[c] <= sync2[c];
          fcnt[c] <= '0;
        end else begin
          fcnt[c] <= fcnt[c] + 4'd1;
        end
      end
    end
  end

  // Settle tracking: the RUN transition lands one clock after the last
  // settling strobe, so the decode of a level accepted on that strobe
  // (pins already non-idle at release) is still suppressed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_SETTLE;
      settle_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_SETTLE && strobe && settle_cnt != SETTLE_N)
        settle_cnt <= settle_cnt + 5'd1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == S_SETTLE && settle_cnt == SETTLE_N)
      state_nx = S_RUN;
  end

  // Gray-code step decode of {i,q}: prev -> filt.
  always_comb begin
    up_nx  = 1'b0;
    dn_nx  = 1'b0;
    err_nx = 1'b0;
    if (state == S_RUN) begin
      case ({prev, filt})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: up_nx  = 1'b1;
        4'b0001, 4'b0111, 4'b1110, 4'b1000: dn_nx  = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: err_nx = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev     <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      prev  <= filt;
      up_q  <= up_nx;
      dn_q  <= dn_nx;
      err_q <= err_nx;
      if (err_q)
        sticky_q <= 1'b1;
      else if (bus.err_ack)
        sticky_q <= 1'b0;
    end
  end

  assign bus.i_out      = filt[1];
  assign bus.q_out      = filt[0];
  assign bus.up         = up_q;
  assign bus.dn         = dn_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_qe_input_filter.sv
// Bench for qe_input_filter: two instances (DIV=1 and DIV=4, FILT_LEN=4)
// share clock, reset and pin stimulus; each has a behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_qe_input_filter;

  localparam int FL = 4;

  logic clk = 1'b0;
  logic clr;
  logic en, a, b, ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int D = (g == 0) ? 1 : 4;

    qe_input_filter_if bus ();
    assign bus.en      = en;
    assign bus.a_raw   = a;
    assign bus.b_raw   = b;
    assign bus.err_ack = ack;

    qe_input_filter #(.DIV(D), .FILT_LEN(FL)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
    );

    // Behavioural model: sampled-history window filter, Gray position delta.
    logic [1:0] ms1 = '0, ms2 = '0, lvl = '0, mold = '0, mcur = '0;
    bit qa[$];
    bit qb[$];
    int m_en = 0, m_strobes = 0, m_edge = 0, m_sixth = 0;
    bit m_seen = 0;
    logic m_up = 0, m_dn = 0, m_err = 0, m_sticky = 0;

    always @(posedge clk or posedge clr) begin
      if (clr) begin
        ms1 = '0; ms2 = '0; lvl = '0; mold = '0; mcur = '0;
        qa.delete(); qb.delete();
        m_en = 0; m_strobes = 0; m_edge = 0; m_sixth = 0; m_seen = 0;
        m_up = 0; m_dn = 0; m_err = 0; m_sticky = 0;
      end else begin
        bit strobe, allowed, all_a, all_b;
        int step;
        strobe = en && ((m_en % D) == D - 1);
        m_edge++;
        allowed = m_seen && (m_edge >= m_sixth + 2);
        step = (gpos(mcur) - gpos(mold) + 4) % 4;
        if (m_err) m_sticky = 1;
        else if (ack) m_sticky = 0;
        m_up  = allowed && step == 1;
        m_dn  = allowed && step == 3;
        m_err = allowed && step == 2;
        if (strobe) begin
          qa.push_back(ms2[1]); if (qa.size() > 16) void'(qa.pop_front());
          qb.push_back(ms2[0]); if (qb.size() > 16) void'(qb.pop_front());
          if (qa.size() >= FL) begin
            all_a = 1; all_b = 1;
            for (int i = 0; i < FL; i++) begin
              if (qa[qa.size() - 1 - i] == lvl[1]) all_a = 0;
              if (qb[qb.size() - 1 - i] == lvl[0]) all_b = 0;
            end
            if (all_a) lvl[1] = ~lvl[1];
            if (all_b) lvl[0] = ~lvl[0];
          end
          m_strobes++;
          if (m_strobes == FL + 2) begin m_seen = 1; m_sixth = m_edge; end
        end
        mold = mcur;
        mcur = lvl;
        ms2 = ms1;
        ms1 = {a, b};
        if (en) m_en++;
      end
    end
  end

  task automatic cmp(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, act, exp);
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    cmp("i0",      gi[0].bus.i_out,      gi[0].lvl[1]);
    cmp("q0",      gi[0].bus.q_out,      gi[0].lvl[0]);
    cmp("up0",     gi[0].bus.up,         gi[0].m_up);
    cmp("dn0",     gi[0].bus.dn,         gi[0].m_dn);
    cmp("err0",    gi[0].bus.err,        gi[0].m_err);
    cmp("sticky0", gi[0].bus.err_sticky, gi[0].m_sticky);
    cmp("i1",      gi[1].bus.i_out,      gi[1].lvl[1]);
    cmp("q1",      gi[1].bus.q_out,      gi[1].lvl[0]);
    cmp("up1",     gi[1].bus.up,         gi[1].m_up);
    cmp("dn1",     gi[1].bus.dn,         gi[1].m_dn);
    cmp("err1",    gi[1].bus.err,        gi[1].m_err);
    cmp("sticky1", gi[1].bus.err_sticky, gi[1].m_sticky);
  end

  int c_up = 0, c_dn = 0, c_err = 0, hi0 = 0, hi1 = 0;
  always @(negedge clk) begin
    if (gi[0].bus.up)    c_up++;
    if (gi[0].bus.dn)    c_dn++;
    if (gi[0].bus.err)   c_err++;
    if (gi[0].bus.i_out) hi0++;
    if (gi[1].bus.i_out) hi1++;
  end

  int s_up, s_dn, s_err, s_hi0, s_hi1;
  task automatic snap();
    s_up = c_up; s_dn = c_dn; s_err = c_err; s_hi0 = hi0; s_hi1 = hi1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic reset_pulse();
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
  endtask

  initial begin
    int k_i, k_q, k_up, hold;
    bit found;
    clr = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; ack = 1'b0;
    tick(3);
    cmp("reset_i0", gi[0].bus.i_out, 1'b0);
    cmp("reset_sticky0", gi[0].bus.err_sticky, 1'b0);
    clr = 1'b0;
    tick(20);

    // Forward sequence with latency measurement on the first step.
    snap();
    a = 1'b1;
    k_i = 0; k_up = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (gi[0].bus.i_out && k_i == 0) k_i = k;
      if (gi[0].bus.up && k_up == 0) k_up = k;
    end
    check("lat_i", k_i, 6);
    check("lat_up", k_up, 7);
    b = 1'b1; tick(10);
    a = 1'b0; tick(10);
    b = 1'b0; tick(20);
    check("fwd_up", c_up - s_up, 4);
    check("fwd_dn", c_dn - s_dn, 0);
    check("fwd_err", c_err - s_err, 0);

    // Reverse sequence.
    snap();
    b = 1'b1; tick(10);
    a = 1'b1; tick(10);
    b = 1'b0; tick(10);
    a = 1'b0; tick(20);
    check("rev_up", c_up - s_up, 0);
    check("rev_dn", c_dn - s_dn, 4);
    check("rev_err", c_err - s_err, 0);

    // Glitch rejection and minimum accepted width.
    snap();
    a = 1'b1; tick(3); a = 1'b0; tick(15);
    check("glitch3_hi", hi0 - s_hi0, 0);
    check("glitch3_up", c_up - s_up, 0);
    snap();
    a = 1'b1; tick(4); a = 1'b0; tick(20);
    check("pulse4_hi", hi0 - s_hi0, 4);
    check("pulse4_up", c_up - s_up, 1);
    check("pulse4_dn", c_dn - s_dn, 1);

    // Double transition, sticky flag and acknowledge.
    snap();
    a = 1'b1; b = 1'b1; tick(10);
    check("dbl_err", c_err - s_err, 1);
    check("dbl_updn", (c_up - s_up) + (c_dn - s_dn), 0);
    check("sticky_set", gi[0].bus.err_sticky, 1);
    ack = 1'b1; tick(1); ack = 1'b0; tick(1);
    check("sticky_ack", gi[0].bus.err_sticky, 0);
    a = 1'b0; b = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (gi[0].bus.err) found = 1;
    end
    check("err2_seen", found, 1);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("sticky_set_wins", gi[0].bus.err_sticky, 1);
    tick(3);
    check("sticky_hold", gi[0].bus.err_sticky, 1);

    // Pins at 11 through reset release.
    a = 1'b1; b = 1'b1;
    reset_pulse();
    snap();
    k_i = 0; k_q = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (gi[0].bus.i_out && k_i == 0) k_i = k;
      if (gi[0].bus.q_out && k_q == 0) k_q = k;
    end
    tick(20);
    check("rel11_i", k_i, 6);
    check("rel11_q", k_q, 6);
    check("rel11_pulses", (c_up - s_up) + (c_dn - s_dn) + (c_err - s_err), 0);
    check("rel11_sticky", gi[0].bus.err_sticky, 0);

    // DIV=4 instance: width rejection, acceptance, en freeze.
    a = 1'b0; b = 1'b0;
    reset_pulse();
    tick(40);
    snap();
    a = 1'b1; tick(12); a = 1'b0; tick(40);
    check("div4_p12_hi", hi1 - s_hi1, 0);
    snap();
    a = 1'b1; tick(20); a = 1'b0; tick(40);
    check("div4_p20_hi", hi1 - s_hi1, 20);

    reset_pulse();
    tick(40);
    a = 1'b1;
    k_i = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (gi[1].bus.i_out && k_i == 0) k_i = k;
    end
    check("div4_base", k_i, 16);
    a = 1'b0;

    reset_pulse();
    tick(40);
    a = 1'b1;
    k_i = 0;
    for (int k = 1; k <= 100; k++) begin
      en = (k >= 7 && k <= 56) ? 1'b0 : 1'b1;
      tick(1);
      if (gi[1].bus.i_out && k_i == 0) k_i = k;
    end
    en = 1'b1;
    check("div4_frozen", k_i, 66);
    a = 1'b0;
    tick(40);

    // Randomised pins, enable, acknowledge and occasional reset.
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 14);
      end else begin
        hold--;
      end
      en  = ($urandom_range(0, 9) != 0);
      ack = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    clr = 1'b0; en = 1'b1; ack = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
